store_wdata_writer: RTL and testbench
=====================================

Name: store_wdata_writer

Overview:
- Write-direction counterpart of the load-data path in the LSU.
- Takes a store request (address, register data, func3 for sb/sh/sw) from EXU/LSU and lane-aligns the data into a 32-bit bus word.
- Generates byte strobes and runs an AXI4-Lite write transaction (AW/W/B) to DRAM/SoC.
- Returns a completion with a status code to the pipeline. Holds one outstanding store.

Parameters:
- ADDR_W, 32, address width of req_addr and awaddr.
- CHECK_ALIGN, 1, 1 = misaligned sh/sw is rejected without a bus access; 0 = misalignment is ignored and strobes are truncated to the word.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  store request valid.
- req_ready  output  1  writer can accept a request.
- req_addr  input  ADDR_W  byte address.
- req_data  input  32  rs2 value, right-justified.
- req_func3  input  3  0 = sb, 1 = sh, 2 = sw; others illegal.
- awvalid  output  1  AXI write address valid.
- awready  input  1  AXI write address ready.
- awaddr  output  ADDR_W  AXI write address.
- wvalid  output  1  AXI write data valid.
- wready  input  1  AXI write data ready.
- wdata  output  32  AXI write data.
- wstrb  output  4  AXI write byte strobes.
- bvalid  input  1  AXI write response valid.
- bready  output  1  AXI write response ready.
- bresp  input  2  AXI write response code.
- resp_valid  output  1  completion valid.
- resp_ready  input  1  completion accepted.
- resp_code  output  2  00 OK, 01 MISALIGNED, 10 BUS_ERR, 11 ILLEGAL_FUNC3.

Behaviour:
- Reset (async, rst_n low):
  - State = IDLE.
  - awvalid, wvalid, bready and resp_valid are 0.
  - awaddr, wdata, wstrb and resp_code are 0.
  - req_ready is 1 once reset is released.
  - Reset mid-transaction abandons the transaction immediately. No completion is produced.
- States: IDLE, SEND, WAIT_B, RESP. req_ready = (state == IDLE).
- IDLE: on req_valid and req_ready, register the request.
  - func3 not in {0,1,2}: go to RESP with code 11. No bus activity.
  - CHECK_ALIGN = 1 and (sh with addr[0] = 1, or sw with addr[1:0] != 0): go to RESP with code 01. No bus activity.
  - Otherwise go to SEND. awvalid and wvalid rise in the cycle after acceptance.
- Lane placement (registered), with o = addr[1:0]:
  - sb: wdata = {4{data[7:0]}}, wstrb = 4'b0001 << o.
  - sh: wdata = {2{data[15:0]}}, wstrb = (4'b0011 << o), truncated to 4 bits.
  - sw: wdata = data, wstrb = 4'b1111.
  - awaddr = req_addr unmodified.
- SEND: AW and W channels are independent.
  - Each valid stays high, with stable payload, until its own handshake (valid & ready).
  - Each handshake is recorded by an aw_done / w_done flag, and that valid drops the next cycle.
  - Both handshakes may occur in the same cycle, in either order, or with any gap.
  - When both are done, go to WAIT_B. Clear the flags.
- WAIT_B: bready = 1.
  - On bvalid, go to RESP with resp_code = 00 if bresp == 00, else 10. bready drops.
  - bvalid arriving before both AW and W handshakes is a protocol violation. It is not handled.
- RESP: resp_valid = 1 and resp_code stays stable until resp_ready. On handshake go to IDLE.
- Latency:
  - Best case is request accept at cycle N, AW/W handshake at N+1, B at N+2, resp_valid at N+3.
  - Back-to-back throughput is one store per (AW/W + B + resp) round trip.
  - A new request is accepted in the cycle after the resp handshake. Requests are never accepted while resp_valid is pending.
- req_data, req_addr and req_func3 are sampled only at acceptance. Later changes on these inputs have no effect.

Test Plan:
- sb, addr 0x8000_0003, data 0x1234_56AB, ready always high -> awaddr 0x8000_0003, wdata 0xABAB_ABAB, wstrb 4'b1000; resp_code 00 three cycles after accept.
- sh, addr 0x8000_0002, data 0xDEAD_BEEF -> wdata 0xBEEF_BEEF, wstrb 4'b1100. Then sw at 0x8000_0004, data 0xCAFE_F00D -> wdata 0xCAFE_F00D, wstrb 4'b1111.
- Backpressure: awready held low 3 cycles, wready high -> W handshakes first, wvalid drops, awvalid and awaddr stay stable until awready; exactly one AW and one W handshake occur.
- sw at 0x8000_0006 (CHECK_ALIGN = 1) -> no awvalid or wvalid ever; resp_code 01. func3 = 3 -> resp_code 11.
- bresp = 2'b10 -> resp_code 10. resp_ready held low 4 cycles -> resp_valid and resp_code held, req_ready stays 0.
- rst_n pulsed low while in SEND -> awvalid, wvalid and resp_valid go to 0 immediately; after release, req_ready = 1 and the next request completes normally.

Source files
------------

// File: rtl/store_wdata_writer_if.sv
// store_wdata_writer_if: store request, AXI4-Lite write channels and completion bundle
interface store_wdata_writer_if #(parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic [2:0]        req_func3;
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid;
  logic              wready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic              resp_valid;
  logic              resp_ready;
  logic [1:0]        resp_code;
  modport slave (
    input  req_valid, req_addr, req_data, req_func3, awready, wready, bvalid, bresp, resp_ready,
    output req_ready, awvalid, awaddr, wvalid, wdata, wstrb, bready, resp_valid, resp_code
  );
  modport master (
    output req_valid, req_addr, req_data, req_func3, awready, wready, bvalid, bresp, resp_ready,
    input  req_ready, awvalid, awaddr, wvalid, wdata, wstrb, bready, resp_valid, resp_code
  );
endinterface

// File: rtl/store_wdata_writer.sv
// store_wdata_writer: lane-aligns sb/sh/sw data and issues one AXI4-Lite write at a time
module store_wdata_writer #(
  parameter int ADDR_W      = 32,
  parameter bit CHECK_ALIGN = 1
) (
  input logic                clk,
  input logic                rst_n,
  store_wdata_writer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_B, RESP} state_t;
  state_t     state, state_nx;
  logic       aw_done, w_done, aw_hs, w_hs, bus_done, acc, illegal, misal;
  logic [1:0] o;
  assign o            = bus.req_addr[1:0];
  assign acc          = bus.req_valid && state == IDLE;
  assign aw_hs        = bus.awvalid && bus.awready;
  assign w_hs         = bus.wvalid && bus.wready;
  assign bus_done     = (aw_done || aw_hs) && (w_done || w_hs);
  assign illegal      = bus.req_func3 > 3'd2;
  assign misal        = CHECK_ALIGN && ((bus.req_func3 == 3'd1 && o[0]) || (bus.req_func3 == 3'd2 && o != 2'd0));
  assign bus.req_ready  = state == IDLE;
  assign bus.awvalid    = state == SEND && !aw_done;
  assign bus.wvalid     = state == SEND && !w_done;
  assign bus.bready     = state == WAIT_B;
  assign bus.resp_valid = state == RESP;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state: rejected requests skip the bus and go straight to the completion
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE   ? (!acc ? IDLE : (illegal || misal) ? RESP : SEND)
             : state == SEND   ? (bus_done ? WAIT_B : SEND)
             : state == WAIT_B ? (bus.bvalid ? RESP : WAIT_B)
             : (bus.resp_ready ? IDLE : RESP);
  end
  // channel-done flags, lane-placed payload captured at accept, and completion code
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      bus.awaddr    <= '0;
      bus.wdata     <= '0;
      bus.wstrb     <= '0;
      bus.resp_code <= '0;
    end else begin
      aw_done <= state == SEND && !bus_done && (aw_done || aw_hs);
      w_done  <= state == SEND && !bus_done && (w_done || w_hs);
      if (acc) begin
        bus.awaddr    <= bus.req_addr;
        bus.wdata     <= bus.req_func3 == 3'd0 ? {4{bus.req_data[7:0]}}
                       : bus.req_func3 == 3'd1 ? {2{bus.req_data[15:0]}} : bus.req_data;
        bus.wstrb     <= bus.req_func3 == 3'd0 ? 4'b0001 << o
                       : bus.req_func3 == 3'd1 ? 4'b0011 << o : 4'b1111;
        bus.resp_code <= illegal ? 2'b11 : misal ? 2'b01 : 2'b00;
      end else if (state == WAIT_B && bus.bvalid)
        bus.resp_code <= bus.bresp == 2'b00 ? 2'b00 : 2'b10;
    end
endmodule

// File: tb/tb_store_wdata_writer.sv
// tb_store_wdata_writer: vector table, directed corner sequences and random stores against a reference model
module tb_store_wdata_writer;
  typedef struct packed {
    logic [1:0]  code;
    logic [31:0] wd;
    logic [3:0]  st;
    logic        bus;
  } exp_t;
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  f;
    logic [1:0]  br;
    exp_t        e;
    int          rd;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n;
  int total = 0, bad = 0;
  int aw_cnt = 0, w_cnt = 0, v_cyc = 0, unstable = 0;
  logic [31:0] cap_awaddr, cap_wdata, pend_addr, pend_wdata;
  logic [3:0]  cap_wstrb, pend_wstrb;
  logic        aw_pend = 1'b0, w_pend = 1'b0;
  vec_t vecs[$];
  store_wdata_writer_if #(.ADDR_W(32)) bus();
  store_wdata_writer #(.ADDR_W(32), .CHECK_ALIGN(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // bus monitor: handshakes are decided by the values seen half a cycle before the edge
  always @(negedge clk) begin
    if (!rst_n) begin
      aw_pend = 1'b0;
      w_pend  = 1'b0;
    end else begin
      if (bus.awvalid && bus.awready) begin aw_cnt++; cap_awaddr = bus.awaddr; end
      if (bus.wvalid && bus.wready) begin w_cnt++; cap_wdata = bus.wdata; cap_wstrb = bus.wstrb; end
      if (bus.awvalid || bus.wvalid) v_cyc++;
      if (aw_pend && (!bus.awvalid || bus.awaddr != pend_addr)) unstable++;
      if (w_pend && (!bus.wvalid || bus.wdata != pend_wdata || bus.wstrb != pend_wstrb)) unstable++;
      aw_pend = bus.awvalid && !bus.awready;
      w_pend = bus.wvalid && !bus.wready;
      pend_addr = bus.awaddr;
      pend_wdata = bus.wdata;
      pend_wstrb = bus.wstrb;
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic exp_t mk(input logic [1:0] code, input logic [31:0] wd, input logic [3:0] st, input logic b);
    exp_t e;
    e.code = code; e.wd = wd; e.st = st; e.bus = b;
    return e;
  endfunction
  // reference: access size in bytes, natural alignment, replicated lanes via multiplication
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f, input logic [1:0] br);
    exp_t e;
    int n, o;
    e = '0;
    o = int'(a[1:0]);
    if (f > 3'd2) begin e.code = 2'b11; return e; end
    n = 1 << f;
    if (o % n != 0) begin e.code = 2'b01; return e; end
    e.bus = 1'b1;
    e.code = br == 2'b00 ? 2'b00 : 2'b10;
    e.st = 4'(((1 << n) - 1) << o);
    e.wd = f == 3'd0 ? {24'h0, d[7:0]} * 32'h01010101
         : f == 3'd1 ? {16'h0, d[15:0]} * 32'h00010001 : d;
    return e;
  endfunction
  task automatic add(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f, input logic [1:0] br, input exp_t e, input int rd);
    vec_t v;
    v.a = a; v.d = d; v.f = f; v.br = br; v.e = e; v.rd = rd;
    vecs.push_back(v);
  endtask
  task automatic run(input string nm, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                     input logic [1:0] br, input exp_t e, input int pr, input int rd, input int awlow, input bit fast);
    int n, aw0, w0, v0, u0;
    n = 0;
    while (!bus.req_ready && n < 50) begin cyc(); n++; end
    chk({nm, " req_ready before"}, 32'(bus.req_ready), 1);
    aw0 = aw_cnt; w0 = w_cnt; v0 = v_cyc; u0 = unstable;
    bus.req_valid = 1'b1; bus.req_addr = a; bus.req_data = d; bus.req_func3 = f;
    cyc();
    bus.req_valid = 1'b0; bus.req_addr = $urandom; bus.req_data = $urandom; bus.req_func3 = 3'($urandom);
    n = 0;
    while (!bus.resp_valid && n < 100) begin
      if (awlow > 0 && n == 2) begin
        chk({nm, " awvalid held"}, 32'(bus.awvalid), 1);
        chk({nm, " wvalid dropped"}, 32'(bus.wvalid), 0);
        chk({nm, " awaddr held"}, bus.awaddr, a);
      end
      bus.awready = n >= awlow && $urandom_range(0, 99) < pr;
      bus.wready = $urandom_range(0, 99) < pr;
      bus.bvalid = bus.bvalid || (aw_cnt - aw0 == 1 && w_cnt - w0 == 1 && $urandom_range(0, 99) < pr);
      bus.bresp = br;
      cyc();
      n++;
    end
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;
    chk({nm, " resp_valid"}, 32'(bus.resp_valid), 1);
    chk({nm, " resp_code"}, 32'(bus.resp_code), 32'(e.code));
    if (fast) chk({nm, " latency"}, n + 1, e.bus ? 3 : 1);
    chk({nm, " aw handshakes"}, aw_cnt - aw0, 32'(e.bus));
    chk({nm, " w handshakes"}, w_cnt - w0, 32'(e.bus));
    chk({nm, " payload stable"}, unstable - u0, 0);
    if (!e.bus) chk({nm, " valid cycles"}, v_cyc - v0, 0);
    else begin
      chk({nm, " awaddr"}, cap_awaddr, a);
      chk({nm, " wdata"}, cap_wdata, e.wd);
      chk({nm, " wstrb"}, 32'(cap_wstrb), 32'(e.st));
    end
    for (int i = 0; i < rd; i++) begin
      cyc();
      chk({nm, " resp_valid hold"}, 32'(bus.resp_valid), 1);
      chk({nm, " resp_code hold"}, 32'(bus.resp_code), 32'(e.code));
      chk({nm, " req_ready low"}, 32'(bus.req_ready), 0);
    end
    bus.resp_ready = 1'b1;
    cyc();
    bus.resp_ready = 1'b0;
    chk({nm, " resp_valid drop"}, 32'(bus.resp_valid), 0);
    chk({nm, " req_ready after"}, 32'(bus.req_ready), 1);
  endtask
  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    logic [31:0] a, d;
    logic [2:0]  f;
    logic [1:0]  br;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_data = '0; bus.req_func3 = '0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = '0; bus.resp_ready = 1'b0;
    #1;
    chk("rst awvalid", 32'(bus.awvalid), 0);
    chk("rst wvalid", 32'(bus.wvalid), 0);
    chk("rst bready", 32'(bus.bready), 0);
    chk("rst resp_valid", 32'(bus.resp_valid), 0);
    chk("rst awaddr", bus.awaddr, 0);
    chk("rst wdata", bus.wdata, 0);
    chk("rst wstrb", 32'(bus.wstrb), 0);
    chk("rst resp_code", 32'(bus.resp_code), 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    chk("rst req_ready", 32'(bus.req_ready), 1);
    add(32'h8000_0003, 32'h1234_56AB, 3'd0, 2'b00, mk(2'b00, 32'hABAB_ABAB, 4'b1000, 1'b1), 0);
    add(32'h8000_0002, 32'hDEAD_BEEF, 3'd1, 2'b00, mk(2'b00, 32'hBEEF_BEEF, 4'b1100, 1'b1), 0);
    add(32'h8000_0004, 32'hCAFE_F00D, 3'd2, 2'b00, mk(2'b00, 32'hCAFE_F00D, 4'b1111, 1'b1), 0);
    add(32'h8000_0006, 32'h1111_2222, 3'd2, 2'b00, mk(2'b01, 32'h0, 4'b0000, 1'b0), 0);
    add(32'h8000_0000, 32'h3333_4444, 3'd3, 2'b00, mk(2'b11, 32'h0, 4'b0000, 1'b0), 0);
    add(32'h0000_0010, 32'h0000_005A, 3'd0, 2'b10, mk(2'b10, 32'h5A5A_5A5A, 4'b0001, 1'b1), 4);
    add(32'h8000_0001, 32'h0000_9999, 3'd1, 2'b00, mk(2'b01, 32'h0, 4'b0000, 1'b0), 0);
    add(32'h0000_0001, 32'hFFFF_FF77, 3'd0, 2'b00, mk(2'b00, 32'h7777_7777, 4'b0010, 1'b1), 1);
    add(32'h0000_0000, 32'h0000_1234, 3'd1, 2'b11, mk(2'b10, 32'h1234_1234, 4'b0011, 1'b1), 0);
    add(32'h0000_0020, 32'h0000_0000, 3'd7, 2'b00, mk(2'b11, 32'h0, 4'b0000, 1'b0), 2);
    foreach (vecs[i]) run($sformatf("vec%0d", i), vecs[i].a, vecs[i].d, vecs[i].f, vecs[i].br, vecs[i].e, 100, vecs[i].rd, 0, 1'b1);
    run("aw_backpressure", 32'h8000_0008, 32'h0BAD_CAFE, 3'd2, 2'b00, model(32'h8000_0008, 32'h0BAD_CAFE, 3'd2, 2'b00), 100, 0, 3, 1'b0);
    bus.req_valid = 1'b1; bus.req_addr = 32'h8000_0100; bus.req_data = 32'h5555_AAAA; bus.req_func3 = 3'd2;
    cyc();
    bus.req_valid = 1'b0;
    chk("pre-reset awvalid", 32'(bus.awvalid), 1);
    rst_n = 1'b0;
    #1;
    chk("mid-reset awvalid", 32'(bus.awvalid), 0);
    chk("mid-reset wvalid", 32'(bus.wvalid), 0);
    chk("mid-reset resp_valid", 32'(bus.resp_valid), 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post-reset req_ready", 32'(bus.req_ready), 1);
    run("post_reset", 32'h8000_0102, 32'h0000_ABCD, 3'd1, 2'b00, model(32'h8000_0102, 32'h0000_ABCD, 3'd1, 2'b00), 100, 0, 0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      d = $urandom;
      f = $urandom_range(0, 9) == 0 ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      br = $urandom_range(0, 3) == 0 ? 2'($urandom_range(1, 3)) : 2'b00;
      run($sformatf("rnd%0d", i), a, d, f, br, model(a, d, f, br), $urandom_range(30, 100), $urandom_range(0, 2), 0, 1'b0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
